// File: rtl/four_bit_unsigned_multiplier_if.sv
// Operand/result bundle for the 4x4 unsigned multiplier.
// Handshake: a/b are consumed at every rising edge where in_valid=1 (no ready, no
// backpressure); out_valid=1 marks exactly the cycles after an edge that loaded a new product.
interface four_bit_unsigned_multiplier_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [7:0] product;
    logic       out_valid;

    modport master (
        output a,
        output b,
        output in_valid,
        input  product,
        input  out_valid
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output product,
        output out_valid
    );
endinterface

// File: rtl/four_bit_unsigned_multiplier.sv
// Structural 4x4 unsigned array multiplier (AND partial products, HA/FA ripple rows).
// Define FOUR_BIT_UNSIGNED_MULTIPLIER_PIPE2_EN to register the array after rows 0-1 (latency 2).
module four_bit_unsigned_multiplier (
    input  logic                           clk,
    input  logic                           rst,
    four_bit_unsigned_multiplier_if.slave  bus
);

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // One array row: x is the upper part of the running sum, p the next partial-product row.
    // Returns {carry_out, sum[3:0]}; sum[0] is a finished product bit.
    function automatic logic [4:0] add_row(input logic [3:0] x, input logic [3:0] p);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] c3;
        c0 = ha(x[0], p[0]);
        c1 = fa(x[1], p[1], c0[1]);
        c2 = fa(x[2], p[2], c1[1]);
        c3 = fa(x[3], p[3], c2[1]);
        return {c3[1], c3[0], c2[0], c1[0], c0[0]};
    endfunction

    logic [3:0] pp [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = 4'b0000;
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = bus.a[j] & bus.b[i];
            end
        end
    end

    logic [4:0] row1;
    logic [4:0] row2;
    logic [4:0] row3;
    logic [7:0] prod_next;
    logic       stage_valid;

    assign row1 = add_row({1'b0, pp[0][3:1]}, pp[1]);

`ifdef FOUR_BIT_UNSIGNED_MULTIPLIER_PIPE2_EN
    logic [4:0] s1_sum;
    logic       s1_bit0;
    logic [3:0] s1_pp2;
    logic [3:0] s1_pp3;
    logic       s1_valid;

    // Mid-array register: rows 0-1 reduced, rows 2-3 carried forward as raw partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sum   <= 5'd0;
            s1_bit0  <= 1'b0;
            s1_pp2   <= 4'd0;
            s1_pp3   <= 4'd0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum  <= row1;
                s1_bit0 <= pp[0][0];
                s1_pp2  <= pp[2];
                s1_pp3  <= pp[3];
            end
        end
    end

    assign row2        = add_row(s1_sum[4:1], s1_pp2);
    assign row3        = add_row(row2[4:1], s1_pp3);
    assign prod_next   = {row3, row2[0], s1_sum[0], s1_bit0};
    assign stage_valid = s1_valid;
`else
    assign row2        = add_row(row1[4:1], pp[2]);
    assign row3        = add_row(row2[4:1], pp[3]);
    assign prod_next   = {row3, row2[0], row1[0], pp[0][0]};
    assign stage_valid = bus.in_valid;
`endif

    logic [7:0] prod_q;
    logic       vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= 8'h00;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= stage_valid;
            if (stage_valid) begin
                prod_q <= prod_next;
            end
        end
    end

    assign bus.product   = prod_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_four_bit_unsigned_multiplier.sv
// Directed + random bench for four_bit_unsigned_multiplier against an arithmetic reference.
module tb_four_bit_unsigned_multiplier;

`ifdef FOUR_BIT_UNSIGNED_MULTIPLIER_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    four_bit_unsigned_multiplier_if bus();

    four_bit_unsigned_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference: results in flight as {valid, a*b}, L-1 entries deep between edges.
    logic [8:0] exp_q[$];
    logic [7:0] m_prod;
    logic       m_valid;

    task automatic model_step(input logic [3:0] ta, input logic [3:0] tb_, input logic tv, input logic tr);
        logic [8:0] head;
        logic [7:0] p;
        if (tr) begin
            exp_q.delete();
            for (int k = 0; k < LAT - 1; k++) exp_q.push_back(9'd0);
            m_prod  = 8'h00;
            m_valid = 1'b0;
        end else begin
            p = tv ? (8'(ta) * 8'(tb_)) : 8'h00;
            exp_q.push_back({tv, p});
            head    = exp_q.pop_front();
            m_valid = head[8];
            if (head[8]) m_prod = head[7:0];
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver: apply inputs, take one edge, advance model, sample 1 time unit later
    task automatic cycle(input logic [3:0] ta, input logic [3:0] tb_, input logic tv, input logic tr,
                         input string tag);
        bus.a        = ta;
        bus.b        = tb_;
        bus.in_valid = tv;
        rst          = tr;
        @(posedge clk);
        model_step(ta, tb_, tv, tr);
        #1;
        check({tag, "_prod"}, bus.product, m_prod);
        check({tag, "_vld"}, {7'd0, bus.out_valid}, {7'd0, m_valid});
    endtask

    initial begin
        logic [3:0] sa [6];
        logic [3:0] sb [6];
        logic [7:0] sp [6];
        logic [7:0] got_q[$];
        logic [3:0] ra;
        logic [3:0] rb;

        sa = '{4'd0, 4'd3, 4'd7, 4'd0, 4'd1, 4'd15};
        sb = '{4'd0, 4'd2, 4'd5, 4'd5, 4'd10, 4'd15};
        sp = '{8'd0, 8'd6, 8'd35, 8'd0, 8'd10, 8'd225};
        m_prod  = 8'h00;
        m_valid = 1'b0;

        // Scenario 1: reset held two cycles with a live operand pair
        for (int k = 0; k < 2; k++) begin
            cycle(4'd15, 4'd15, 1'b1, 1'b1, "s1_reset");
            check("s1_reset_prod_zero", bus.product, 8'h00);
            check("s1_reset_vld_zero", {7'd0, bus.out_valid}, 8'h00);
        end

        // Scenario 2: back-to-back pairs, results collected in order
        for (int k = 0; k < 6; k++) begin
            cycle(sa[k], sb[k], 1'b1, 1'b0, "s2_stream");
            if (bus.out_valid) got_q.push_back(bus.product);
        end
        for (int k = 0; k < LAT - 1; k++) begin
            cycle(4'd0, 4'd0, 1'b0, 1'b0, "s2_drain");
            if (bus.out_valid) got_q.push_back(bus.product);
        end
        check("s2_result_count", 8'(got_q.size()), 8'd6);
        for (int k = 0; k < 6; k++) begin
            check("s2_result", (k < got_q.size()) ? got_q[k] : 8'hxx, sp[k]);
        end
        cycle(4'd0, 4'd0, 1'b0, 1'b0, "s2_idle");

        // Scenario 3: single valid pair then idle with different operands, then X operands
        cycle(4'd7, 4'd5, 1'b1, 1'b0, "s3_load");
        for (int k = 0; k < LAT + 1; k++) cycle(4'd9, 4'd9, 1'b0, 1'b0, "s3_hold");
        check("s3_hold_prod", bus.product, 8'd35);
        check("s3_hold_vld", {7'd0, bus.out_valid}, 8'h00);
        cycle(4'bxxxx, 4'bxxxx, 1'b0, 1'b0, "s3_xin");
        cycle(4'bxxxx, 4'bxxxx, 1'b0, 1'b0, "s3_xin");
        check("s3_x_hold_prod", bus.product, 8'd35);

        // Scenario 4: 15x15 accepted, reset on the following edge
        cycle(4'd15, 4'd15, 1'b1, 1'b0, "s4_load");
        cycle(4'd15, 4'd15, 1'b0, 1'b1, "s4_reset");
        for (int k = 0; k < 3; k++) begin
            cycle(4'd0, 4'd0, 1'b0, 1'b0, "s4_after");
            check("s4_no_225_prod", bus.product, 8'h00);
            check("s4_no_valid", {7'd0, bus.out_valid}, 8'h00);
        end

        // Scenario 5: operand toggles between edges must not reach product
        cycle(4'd3, 4'd4, 1'b1, 1'b0, "s5_load");
        bus.a = 4'd12;
        #2;
        check("s5_mid_cycle_a12", bus.product, m_prod);
        bus.a = 4'd3;
        #2;
        check("s5_mid_cycle_a3", bus.product, m_prod);
        for (int k = 0; k < LAT; k++) cycle(4'd12, 4'd4, 1'b0, 1'b0, "s5_drain");
        check("s5_sampled_prod", bus.product, 8'd12);

        // Scenario 6: random pairs against the reference
        for (int k = 0; k < 10; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            cycle(ra, rb, 1'b1, 1'b0, "s6_rand");
        end
        for (int k = 0; k < LAT; k++) cycle(4'd0, 4'd0, 1'b0, 1'b0, "s6_drain");

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_unsigned_multiplier.md
FOUR_BIT_UNSIGNED_MULTIPLIER -- requirements
Module: four_bit_unsigned_multiplier

Interface
REQ-001 The block SHALL have no parameters; operand width 4 and product width 8 SHALL be fixed.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 a  input  4  unsigned multiplicand.
REQ-005 b  input  4  unsigned multiplier.
REQ-006 in_valid  input  1  qualifies a and b; tie high for continuous operation.
REQ-007 product  output  8  registered unsigned product a*b.
REQ-008 out_valid  output  1  high for exactly the cycles in which product carries a new result.

Function
REQ-009 The datapath SHALL be a structural 4x4 array multiplier:
- 16 AND partial products pp[i][j] = a[j] & b[i].
- Rows reduced with explicit half-adder and full-adder ripple rows.
- No use of the "*" operator.
REQ-010 The result SHALL equal the full unsigned product a*b, range 0..225; no truncation, no overflow, no signed interpretation.
REQ-011 Base latency SHALL be 1 cycle: a and b sampled at edge N with in_valid=1 appear on product at edge N, with out_valid=1 after that edge.
REQ-012 The block SHALL accept a new operand pair every cycle (throughput 1/cycle) with no backpressure.
REQ-013 When in_valid=0 at an edge:
- product SHALL hold its previous value.
- out_valid SHALL be 0 after that edge.
REQ-014 Boundary: either operand 0 SHALL yield 0; a=15, b=15 SHALL yield 225 (8'hE1); operand 1 SHALL yield the other operand zero-extended.
REQ-015 Operand changes between clock edges SHALL NOT affect product; outputs SHALL change only on clock edges.
REQ-016 X/unknown inputs with in_valid=0 SHALL NOT corrupt held outputs.

Reset
REQ-017 When rst=1 at a rising edge, product SHALL become 8'h00 and out_valid SHALL become 0, including any pipeline stage.
REQ-018 rst SHALL take priority over in_valid; an operand pair presented in the reset cycle SHALL be discarded.
REQ-019 A result in flight when reset asserts mid-operation SHALL be discarded and never flagged valid.
REQ-020 The first valid result after reset deassertion SHALL come from the first operands sampled with rst=0 and in_valid=1.

Configuration
REQ-021 Macro FOUR_BIT_UNSIGNED_MULTIPLIER_PIPE2_EN SHALL control an extra pipeline stage.
- Defined: partial-product rows 0-1 are summed and registered mid-array, together with the remaining partial products and the valid bit.
- Defined: latency becomes 2 cycles and throughput stays 1/cycle.
- Defined: all reset and hold rules apply per stage.
REQ-022 Macro undefined: the single-stage behaviour of REQ-011 SHALL apply, and results SHALL be bit-identical in both configurations apart from latency.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios; latency L is 1 without the macro and 2 with it:
- Scenario 1: rst=1 for 2 cycles with a=15, b=15, in_valid=1 -> product=0x00 and out_valid=0 throughout the reset.
- Scenario 2: back-to-back pairs with in_valid=1, namely (0,0), (3,2), (7,5), (0,5), (1,10), (15,15) -> products 0, 6, 35, 0, 10, 225 on consecutive cycles after L cycles, with out_valid=1 on each.
- Scenario 3: a=7, b=5, in_valid=1 for one cycle, then in_valid=0 with a=9, b=9 -> product holds 35 and out_valid drops to 0.
- Scenario 4: a=15, b=15 accepted, then rst asserted before the result emerges (PIPE2 build) -> 225 never appears and out_valid stays 0.
- Scenario 5: operands toggled between edges (a 3->12->3, b=4) -> product changes only at edges and equals 12 for the sampled pair.
- Scenario 6: 10 random pairs of 0..15 compared against a reference model -> every product equals a*b with exact latency L.
